// File: rtl/conv_layer_scheduler.sv
// rtl/conv_layer_scheduler.sv - walks a layer table in param SRAM, loads each descriptor,
// launches the conv engine per layer and ping-pongs its buffers, with watchdog and abort.
module conv_layer_scheduler #(
  parameter int PARAM_AW   = 10,
  parameter int MAX_LAYERS = 16,
  parameter int TIMEOUT    = 3000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  output logic                param_en,
  output logic [PARAM_AW-1:0] param_addr,
  input  logic [31:0]         param_rdata,
  output logic                param_write,
  output logic [31:0]         param_wdata,
  output logic                conv_start,
  input  logic                conv_finish,
  output logic [31:0]         cfg0,
  output logic [31:0]         cfg1,
  output logic [31:0]         cfg2,
  output logic [31:0]         cfg3,
  output logic                buf_sel,
  output logic [7:0]          layer_idx,
  output logic                busy,
  output logic                done,
  output logic                err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, HDR, HDR_W, DESC, LAUNCH, RUN, NEXT, FIN} state_t;
  state_t state, state_nxt;

  logic [2:0]      desc_cnt;
  logic [7:0]      num_layers;
  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;
  logic            hdr_empty;
  logic            hdr_big;
  logic            accept;
  logic [7:0]      idx_inc;

  assign param_write = 1'b0;
  assign param_wdata = '0;
  assign idx_inc     = layer_idx + 8'd1;
  // Expiry fires on the TIMEOUT-th RUN cycle of the layer.
  assign wd_expire   = (wd_cnt == WD_W'(TIMEOUT - 1));
  assign hdr_empty   = (param_rdata[7:0] == 8'd0);
  assign hdr_big     = (int'(param_rdata[7:0]) > MAX_LAYERS);
  assign accept      = (state == IDLE) && start && !abort;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    param_en   = 1'b0;
    param_addr = '0;
    case (state)
      IDLE:   if (accept) state_nxt = HDR;
      HDR: begin
        param_en  = 1'b1;
        state_nxt = HDR_W;
      end
      HDR_W:  state_nxt = (hdr_empty || hdr_big) ? FIN : DESC;
      // desc_cnt 0..3 issue reads; 1..4 capture the word returned a cycle later.
      DESC: begin
        if (desc_cnt != 3'd4) begin
          param_en   = 1'b1;
          param_addr = PARAM_AW'(1) + (PARAM_AW'(layer_idx) << 2) + PARAM_AW'(desc_cnt);
        end else begin
          state_nxt = LAUNCH;
        end
      end
      LAUNCH: state_nxt = RUN;
      RUN: begin
        if (conv_finish)    state_nxt = NEXT;
        else if (wd_expire) state_nxt = FIN;
      end
      NEXT:   state_nxt = (idx_inc == num_layers) ? FIN : DESC;
      FIN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && state != IDLE) state_nxt = IDLE;
    busy       = (state != IDLE);
    conv_start = (state == LAUNCH) && !abort;
    done       = (state == FIN) && !abort;
    if (rst) begin
      param_en   = 1'b0;
      param_addr = '0;
      busy       = 1'b0;
      conv_start = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      desc_cnt   <= 3'd0;
      num_layers <= 8'd0;
      wd_cnt     <= '0;
      cfg0       <= '0;
      cfg1       <= '0;
      cfg2       <= '0;
      cfg3       <= '0;
      buf_sel    <= 1'b0;
      layer_idx  <= 8'd0;
      err        <= 1'b0;
    end else begin
      desc_cnt <= 3'd0;
      if (accept) begin
        err       <= 1'b0;
        layer_idx <= 8'd0;
        buf_sel   <= 1'b0;
      end
      // An abort freezes all run context where it stands.
      if (!abort) begin
        case (state)
          HDR_W: begin
            num_layers <= param_rdata[7:0];
            if (hdr_big) err <= 1'b1;
          end
          DESC: begin
            desc_cnt <= desc_cnt + 3'd1;
            case (desc_cnt)
              3'd1:    cfg0 <= param_rdata;
              3'd2:    cfg1 <= param_rdata;
              3'd3:    cfg2 <= param_rdata;
              3'd4:    cfg3 <= param_rdata;
              default: ;
            endcase
          end
          LAUNCH: wd_cnt <= '0;
          RUN: begin
            if (wd_cnt != WD_W'(TIMEOUT)) wd_cnt <= wd_cnt + WD_W'(1);
            if (wd_expire && !conv_finish) err <= 1'b1;
          end
          NEXT: begin
            buf_sel   <= ~buf_sel;
            layer_idx <= idx_inc;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// tb/tb_conv_layer_scheduler.sv - randomized self-checking bench for conv_layer_scheduler
// with param SRAM and conv engine responders and an arithmetic timing/address model.
module tb_conv_layer_scheduler;
  localparam int AW  = 10;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          param_en;
  logic [AW-1:0] param_addr;
  logic [31:0]   param_rdata = 32'd0;
  logic          param_write;
  logic [31:0]   param_wdata;
  logic          conv_start;
  logic          conv_finish = 1'b0;
  logic [31:0]   cfg0, cfg1, cfg2, cfg3;
  logic          buf_sel;
  logic [7:0]    layer_idx;
  logic          busy, done, err;

  conv_layer_scheduler #(.PARAM_AW(AW), .MAX_LAYERS(16), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .param_en(param_en), .param_addr(param_addr), .param_rdata(param_rdata),
    .param_write(param_write), .param_wdata(param_wdata),
    .conv_start(conv_start), .conv_finish(conv_finish),
    .cfg0(cfg0), .cfg1(cfg1), .cfg2(cfg2), .cfg3(cfg3),
    .buf_sel(buf_sel), .layer_idx(layer_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [31:0] w0, w1, w2, w3;
    logic        bs;
    logic [7:0]  idx;
  } launch_t;

  logic [31:0]   mem [0:(1<<AW)-1];
  int            cyc = 0;
  int            c0 = 0;
  int            fin_at = -1;
  int            fin_delay = 0;
  int            spur_fin = -1;
  logic          rd_pend = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  int            rd_q[$];
  launch_t       ls_q[$];
  int            done_q[$];
  logic          done_err = 1'b0;
  int            n_pass = 0;
  int            n_fail = 0;

  // Memory returns data the cycle after a read; the engine answers fin_delay cycles after launch.
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rd_pend) param_rdata = mem[rd_addr];
    else         param_rdata = $urandom;
    conv_finish = (cyc == fin_at) || (cyc == spur_fin);
  end

  always @(negedge clk) begin
    launch_t lt;
    if (start && !busy && !abort && !rst) begin
      rd_q.delete();
      ls_q.delete();
      done_q.delete();
      c0 = cyc;
    end
    rd_pend = param_en;
    rd_addr = param_addr;
    if (param_en) rd_q.push_back(int'(param_addr));
    if (conv_start) begin
      lt.cyc = cyc; lt.w0 = cfg0; lt.w1 = cfg1; lt.w2 = cfg2; lt.w3 = cfg3;
      lt.bs = buf_sel; lt.idx = layer_idx;
      ls_q.push_back(lt);
      fin_at = (fin_delay > 0) ? cyc + fin_delay : -1;
    end else if (!busy) begin
      fin_at = -1;
    end
    if (done) begin
      done_q.push_back(cyc);
      done_err = err;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_net(input int n, input logic [31:0] hi);
    mem[0] = {hi[31:8], 8'(n)};
    for (int i = 1; i <= 4 * n; i++) mem[i] = $urandom;
  endtask

  task automatic start_run();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    @(negedge clk);
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(tag, busy, 0);
  endtask

  // Expected behaviour of an n-layer network with engine latency d.
  task automatic check_run(input int n, input int d);
    chk("read_count", rd_q.size(), 1 + 4 * n);
    for (int i = 0; i < rd_q.size() && i <= 4 * n; i++) chk("read_addr", rd_q[i], i);
    chk("launch_count", ls_q.size(), n);
    for (int k = 0; k < ls_q.size() && k < n; k++) begin
      chk("launch_cycle", ls_q[k].cyc - c0, 8 + k * (d + 7));
      chk("launch_cfg0", ls_q[k].w0, mem[1 + 4 * k]);
      chk("launch_cfg1", ls_q[k].w1, mem[2 + 4 * k]);
      chk("launch_cfg2", ls_q[k].w2, mem[3 + 4 * k]);
      chk("launch_cfg3", ls_q[k].w3, mem[4 + 4 * k]);
      chk("launch_buf_sel", ls_q[k].bs, k % 2);
      chk("launch_idx", ls_q[k].idx, k);
    end
    chk("done_count", done_q.size(), 1);
    if (done_q.size() > 0) chk("done_cycle", done_q[0] - c0, 8 + (n - 1) * (d + 7) + d + 2);
    chk("final_buf_sel", buf_sel, n % 2);
    chk("final_layer_idx", layer_idx, n);
    chk("final_err", err, 0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_conv_start"}, conv_start, 0);
    chk({tag, "_param_en"}, param_en, 0);
    chk({tag, "_param_addr"}, param_addr, 0);
    chk({tag, "_buf_sel"}, buf_sel, 0);
    chk({tag, "_layer_idx"}, layer_idx, 0);
    chk({tag, "_cfg"}, {cfg0 | cfg1, cfg2 | cfg3}, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int n, d, k;
    repeat (3) @(negedge clk);
    check_all_zero("in_reset");
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_all_zero("after_reset");

    @(posedge clk); #1; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1; start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("abort_beats_start", busy, 0);

    load_net(2, 32'd0); fin_delay = 10;
    start_run(); wait_idle("two_layer_idle"); check_run(2, 10);

    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, 6); d = $urandom_range(1, 15);
      load_net(n, $urandom); fin_delay = d;
      start_run(); wait_idle("rand_idle"); check_run(n, d);
    end

    load_net(16, $urandom); fin_delay = 1;
    start_run(); wait_idle("max_idle"); check_run(16, 1);

    load_net(1, 32'd0); fin_delay = TMO;
    start_run(); wait_idle("coincide_idle"); check_run(1, TMO);

    load_net(0, $urandom);
    start_run(); wait_idle("empty_idle");
    chk("empty_reads", rd_q.size(), 1);
    if (rd_q.size() > 0) chk("empty_addr", rd_q[0], 0);
    chk("empty_launches", ls_q.size(), 0);
    chk("empty_done_count", done_q.size(), 1);
    if (done_q.size() > 0) chk("empty_done_cycle", done_q[0] - c0, 3);
    chk("empty_err", err, 0);

    load_net(17, 32'd0);
    start_run(); wait_idle("big_idle");
    chk("big_reads", rd_q.size(), 1);
    chk("big_launches", ls_q.size(), 0);
    chk("big_done_count", done_q.size(), 1);
    chk("big_done_err", done_err, 1);
    chk("big_err_sticky", err, 1);

    load_net(1, 32'd0); fin_delay = 0;
    start_run(); wait_idle("wd_idle");
    chk("wd_launches", ls_q.size(), 1);
    chk("wd_done_count", done_q.size(), 1);
    if (done_q.size() > 0) chk("wd_done_cycle", done_q[0] - c0, 9 + TMO);
    chk("wd_done_err", done_err, 1);
    load_net(0, 32'd0);
    start_run();
    @(negedge clk);
    chk("err_cleared_by_start", err, 0);
    wait_idle("wd_clear_idle");

    load_net(3, $urandom); fin_delay = 10;
    start_run();
    k = 0;
    while (ls_q.size() < 2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("abort_layer1_launched", ls_q.size(), 2);
    @(posedge clk); #1; abort = 1'b1;
    @(negedge clk);
    chk("abort_busy_same_cycle", busy, 1);
    chk("abort_no_done", done, 0);
    @(posedge clk); #1; abort = 1'b0;
    @(negedge clk);
    chk("abort_busy_drops", busy, 0);
    chk("abort_hold_idx", layer_idx, 1);
    chk("abort_hold_buf_sel", buf_sel, 1);
    chk("abort_hold_cfg0", cfg0, mem[5]);
    chk("abort_done_count", done_q.size(), 0);
    load_net(1, 32'd0); fin_delay = 5;
    start_run(); wait_idle("restart_idle"); check_run(1, 5);

    load_net(2, $urandom); fin_delay = 10;
    start_run();
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_param_en", param_en, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    check_all_zero("mid_rst");

    load_net(2, $urandom); fin_delay = 10;
    start_run();
    spur_fin = c0 + 4;
    while (cyc < c0 + 12) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_idle("spurious_idle"); check_run(2, 10);
    spur_fin = -1;

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

endmodule
